// File: rtl/line_fetch_engine.sv
// line_fetch_engine: fetches one frame line from memory in bursts and streams the pixels into a pixel FIFO
//   clk, reset                       : single clock, synchronous active-high reset
//   mem_calib_done                   : asynchronous memory calibration flag (synchronised internally)
//   x_size, y_size, line_y, line_req : frame geometry and line request, latched on acceptance
//   abort                            : cancel the line in progress
//   line_busy, line_done             : line in progress / one-cycle completion pulse
//   cmd_*                            : memory read command port
//   rd_en, rd_data, rd_empty         : first-word-fall-through memory read data port
//   fifo_wr_en, fifo_din, fifo_almost_full : pixel FIFO write port
module line_fetch_engine #(
    parameter int MAX_BURST     = 64,
    parameter int DATA_W        = 24,
    parameter int BYTES_PER_PIX = 4,
    parameter int BASE_ADDR     = 5242880,
    parameter int ADDR_W        = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_calib_done,
    input  logic [10:0]       x_size,
    input  logic [10:0]       y_size,
    input  logic              line_req,
    input  logic [10:0]       line_y,
    input  logic              abort,
    output logic              line_busy,
    output logic              line_done,
    output logic              cmd_en,
    output logic [2:0]        cmd_instr,
    output logic [5:0]        cmd_bl,
    output logic [ADDR_W-1:0] cmd_byte_addr,
    input  logic              cmd_full,
    output logic              rd_en,
    input  logic [31:0]       rd_data,
    input  logic              rd_empty,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    input  logic              fifo_almost_full
);
    localparam logic [2:0] CALIB = 3'd0;
    localparam logic [2:0] READY = 3'd1;
    localparam logic [2:0] CMD   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    logic [2:0]        state;
    logic [1:0]        calib_sync;
    logic [10:0]       x_lat;
    logic [21:0]       line_base;
    logic [11:0]       pix_off;
    logic [6:0]        wcnt;
    logic              aborting;
    logic [11:0]       rem;
    logic [6:0]        n;
    logic [ADDR_W-1:0] pix_idx;
    logic              burst_end;
    logic              line_empty;
    logic              unused_rd;
    assign unused_rd = ^rd_data;
    always_comb begin
        rem           = {1'b0, x_lat} - pix_off;
        n             = (rem > 12'(MAX_BURST)) ? 7'(MAX_BURST) : rem[6:0];
        pix_idx       = ADDR_W'(line_base) + ADDR_W'(pix_off);
        // cmd_en is withheld on abort so a cancelled command is never issued
        cmd_en        = (state == CMD) && !cmd_full && !abort;
        cmd_instr     = (state == CMD) ? 3'b001 : 3'b000;
        cmd_bl        = (state == CMD) ? 6'(n - 7'd1) : 6'd0;
        cmd_byte_addr = (state == CMD) ? ADDR_W'(BASE_ADDR) + pix_idx * ADDR_W'(BYTES_PER_PIX) : '0;
        rd_en         = (state == DRAIN) && !rd_empty && !fifo_almost_full;
        // an aborted burst is still popped from memory but discarded
        fifo_wr_en    = rd_en && !aborting && !abort;
        fifo_din      = rd_data[DATA_W-1:0];
        line_done     = (state == DONE);
        burst_end     = rd_en && (wcnt == n - 7'd1);
        line_empty    = (line_y >= y_size) || (x_size == 11'd0);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CALIB;
            calib_sync <= 2'b00;
            x_lat      <= '0;
            line_base  <= '0;
            pix_off    <= '0;
            wcnt       <= '0;
            aborting   <= 1'b0;
            line_busy  <= 1'b0;
        end else begin
            calib_sync <= {calib_sync[0], mem_calib_done};
            case (state)
                CALIB: if (calib_sync[1]) state <= READY;
                READY: if (line_req) begin
                    x_lat     <= x_size;
                    line_base <= 22'(line_y) * 22'(x_size);
                    pix_off   <= '0;
                    line_busy <= 1'b1;
                    state     <= line_empty ? DONE : CMD;
                end
                CMD: if (abort) begin
                    state     <= READY;
                    line_busy <= 1'b0;
                end else if (!cmd_full) begin
                    state    <= DRAIN;
                    wcnt     <= '0;
                    aborting <= 1'b0;
                end
                DRAIN: begin
                    if (abort) aborting <= 1'b1;
                    if (rd_en) wcnt <= wcnt + 7'd1;
                    if (burst_end) begin
                        pix_off <= pix_off + 12'(n);
                        if (aborting || abort) begin
                            state     <= READY;
                            line_busy <= 1'b0;
                        end else begin
                            state <= (pix_off + 12'(n) == {1'b0, x_lat}) ? DONE : CMD;
                        end
                    end
                end
                DONE: begin
                    line_busy <= 1'b0;
                    state     <= READY;
                end
                default: state <= CALIB;
            endcase
        end
    end
endmodule

// File: tb/tb_line_fetch_engine.sv
// tb_line_fetch_engine: directed bench for line_fetch_engine with a simple FWFT memory model
module tb_line_fetch_engine;
    logic        clk = 0, reset = 1, mem_calib_done = 0;
    logic [10:0] x_size = 0, y_size = 480, line_y = 0;
    logic        line_req = 0, abort = 0, cmd_full = 0, fifo_almost_full = 0;
    logic        line_busy, line_done, cmd_en, rd_en, rd_empty, fifo_wr_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic [31:0] rd_data;
    logic [23:0] fifo_din;
    line_fetch_engine dut (
        .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
        .x_size(x_size), .y_size(y_size), .line_req(line_req), .line_y(line_y), .abort(abort),
        .line_busy(line_busy), .line_done(line_done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .cmd_full(cmd_full), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_almost_full(fifo_almost_full)
    );
    always #5 clk = ~clk;
    logic [31:0] mq[$];
    logic        q_empty = 1, mem_hold = 0;
    logic [31:0] q_head = 0;
    int          gword = 0;
    int          cmd_count = 0, wr_count = 0, pop_count = 0, done_count = 0, data_err = 0, viol = 0;
    logic [29:0] caddr[$];
    logic [5:0]  cbl[$];
    int          checks = 0, errors = 0;
    int          c0, w0, p0, d0, a0, e0, v0;
    assign rd_empty = q_empty | mem_hold;
    assign rd_data  = q_head;
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
        end else begin
            if (rd_en) begin
                pop_count++;
                if (mq.size() == 0) viol++;
                else begin
                    if (fifo_wr_en && fifo_din !== mq[0][23:0]) data_err++;
                    mq.pop_front();
                end
            end
            if (fifo_wr_en) wr_count++;
            if (fifo_wr_en && !rd_en) viol++;
            if (rd_en && (rd_empty || fifo_almost_full)) viol++;
            if (cmd_en) begin
                cmd_count++;
                if (cmd_full || cmd_instr !== 3'b001) viol++;
                caddr.push_back(cmd_byte_addr);
                cbl.push_back(cmd_bl);
                for (int i = 0; i <= int'(cmd_bl); i++) begin
                    mq.push_back({8'hA5, 24'(gword)});
                    gword++;
                end
            end
            if (line_done) done_count++;
        end
        q_empty <= (mq.size() == 0);
        q_head  <= (mq.size() != 0) ? mq[0] : 32'd0;
    end
    task automatic snap();
        c0 = cmd_count; w0 = wr_count; p0 = pop_count; d0 = done_count;
        a0 = caddr.size(); e0 = data_err; v0 = viol;
    endtask
    task automatic start_line(input int xs, input int ys, input int ly);
        @(negedge clk);
        x_size = 11'(xs); y_size = 11'(ys); line_y = 11'(ly); line_req = 1;
        @(negedge clk);
        line_req = 0;
    endtask
    task automatic wait_idle(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if (!line_busy) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask
    task automatic wait_wr(input int target, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if (wr_count - w0 == target) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask
    task automatic test_reset();
        reset = 1; mem_calib_done = 0;
        repeat (3) @(negedge clk);
        checks++; if (cmd_en !== 0) begin errors++; $display("FAIL rst_cmd_en: got %0d expected 0", cmd_en); end
        checks++; if (rd_en !== 0) begin errors++; $display("FAIL rst_rd_en: got %0d expected 0", rd_en); end
        checks++; if (fifo_wr_en !== 0) begin errors++; $display("FAIL rst_wr_en: got %0d expected 0", fifo_wr_en); end
        checks++; if (line_busy !== 0) begin errors++; $display("FAIL rst_busy: got %0d expected 0", line_busy); end
        checks++; if (line_done !== 0) begin errors++; $display("FAIL rst_done: got %0d expected 0", line_done); end
        checks++; if (cmd_instr !== 0) begin errors++; $display("FAIL rst_instr: got %0d expected 0", cmd_instr); end
        checks++; if (cmd_bl !== 0) begin errors++; $display("FAIL rst_bl: got %0d expected 0", cmd_bl); end
        checks++; if (cmd_byte_addr !== 0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", cmd_byte_addr); end
        reset = 0; x_size = 64; line_y = 0; line_req = 1;
        repeat (5) @(negedge clk);
        checks++; if (line_busy !== 0) begin errors++; $display("FAIL calib_block: got busy %0d expected 0", line_busy); end
        line_req = 0; mem_calib_done = 1;
        repeat (4) @(negedge clk);
    endtask
    task automatic test_line_640();
        bit ok; int bad = 0;
        snap();
        start_line(640, 480, 2);
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL l640_timeout: busy %0d expected 0", line_busy); end
        checks++; if (cmd_count - c0 !== 10) begin errors++; $display("FAIL l640_cmds: got %0d expected 10", cmd_count - c0); end
        checks++; if (caddr[a0] !== 30'd5248000) begin errors++; $display("FAIL l640_addr0: got %0d expected 5248000", caddr[a0]); end
        for (int i = 0; i < 10 && a0 + i < caddr.size(); i++)
            if (caddr[a0+i] !== 30'(5248000 + 256*i) || cbl[a0+i] !== 6'd63) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL l640_steps: got %0d bad commands expected 0", bad); end
        checks++; if (wr_count - w0 !== 640) begin errors++; $display("FAIL l640_writes: got %0d expected 640", wr_count - w0); end
        checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL l640_done: got %0d expected 1", done_count - d0); end
        checks++; if (data_err - e0 !== 0 || viol - v0 !== 0) begin errors++; $display("FAIL l640_data: got %0d/%0d errors expected 0", data_err - e0, viol - v0); end
    endtask
    task automatic test_line_800();
        bit ok; int bad = 0;
        snap();
        start_line(800, 480, 0);
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL l800_timeout: busy %0d expected 0", line_busy); end
        checks++; if (cmd_count - c0 !== 13) begin errors++; $display("FAIL l800_cmds: got %0d expected 13", cmd_count - c0); end
        for (int i = 0; i < 12 && a0 + i < cbl.size(); i++) if (cbl[a0+i] !== 6'd63) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL l800_bl63: got %0d bad expected 0", bad); end
        checks++; if (cbl[a0+12] !== 6'd31) begin errors++; $display("FAIL l800_last_bl: got %0d expected 31", cbl[a0+12]); end
        checks++; if (caddr[a0+12] !== 30'd5245952) begin errors++; $display("FAIL l800_last_addr: got %0d expected 5245952", caddr[a0+12]); end
        checks++; if (wr_count - w0 !== 800) begin errors++; $display("FAIL l800_writes: got %0d expected 800", wr_count - w0); end
        checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL l800_done: got %0d expected 1", done_count - d0); end
    endtask
    task automatic test_backpressure();
        bit ok; int bad = 0;
        snap();
        start_line(128, 480, 1);
        wait_wr(10, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_start: got %0d writes expected 10", wr_count - w0); end
        fifo_almost_full = 1;
        repeat (20) begin
            @(negedge clk);
            if (rd_en || fifo_wr_en) bad++;
        end
        fifo_almost_full = 0;
        repeat (5) @(negedge clk);
        mem_hold = 1;
        repeat (6) @(negedge clk);
        mem_hold = 0;
        wait_idle(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: busy %0d expected 0", line_busy); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d active cycles expected 0", bad); end
        checks++; if (wr_count - w0 !== 128) begin errors++; $display("FAIL bp_writes: got %0d expected 128", wr_count - w0); end
        checks++; if (data_err - e0 !== 0 || viol - v0 !== 0) begin errors++; $display("FAIL bp_data: got %0d/%0d errors expected 0", data_err - e0, viol - v0); end
        checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL bp_done: got %0d expected 1", done_count - d0); end
    endtask
    task automatic test_empty_line();
        bit ok;
        snap();
        start_line(640, 480, 480);
        checks++; if (line_done !== 1) begin errors++; $display("FAIL empty_done: got %0d expected 1", line_done); end
        @(negedge clk);
        checks++; if (line_done !== 0 || line_busy !== 0) begin errors++; $display("FAIL empty_pulse: got done %0d busy %0d expected 0 0", line_done, line_busy); end
        start_line(0, 480, 0);
        checks++; if (line_done !== 1) begin errors++; $display("FAIL zero_x_done: got %0d expected 1", line_done); end
        wait_idle(10, ok);
        checks++; if (cmd_count - c0 !== 0) begin errors++; $display("FAIL empty_cmds: got %0d expected 0", cmd_count - c0); end
        checks++; if (done_count - d0 !== 2) begin errors++; $display("FAIL empty_dones: got %0d expected 2", done_count - d0); end
    endtask
    task automatic test_cmd_full();
        bit ok; int bad = 0;
        snap();
        cmd_full = 1;
        start_line(64, 480, 5);
        repeat (5) begin
            if (cmd_en) bad++;
            @(negedge clk);
        end
        checks++; if (cmd_byte_addr !== 30'd5244160) begin errors++; $display("FAIL full_addr: got %0d expected 5244160", cmd_byte_addr); end
        cmd_full = 0;
        wait_idle(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout: busy %0d expected 0", line_busy); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_held: got %0d cmd_en cycles expected 0", bad); end
        checks++; if (cmd_count - c0 !== 1) begin errors++; $display("FAIL full_cmds: got %0d expected 1", cmd_count - c0); end
        checks++; if (wr_count - w0 !== 64) begin errors++; $display("FAIL full_writes: got %0d expected 64", wr_count - w0); end
    endtask
    task automatic test_abort_drain();
        bit ok;
        snap();
        start_line(640, 480, 0);
        wait_wr(148, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_reach: got %0d writes expected 148", wr_count - w0); end
        mem_hold = 1;
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0; mem_hold = 0;
        wait_idle(500, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL abort_timeout: busy %0d expected 0", line_busy); end
        checks++; if (wr_count - w0 !== 148) begin errors++; $display("FAIL abort_writes: got %0d expected 148", wr_count - w0); end
        checks++; if (pop_count - p0 !== 192) begin errors++; $display("FAIL abort_pops: got %0d expected 192", pop_count - p0); end
        checks++; if (cmd_count - c0 !== 3) begin errors++; $display("FAIL abort_cmds: got %0d expected 3", cmd_count - c0); end
        checks++; if (done_count - d0 !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_count - d0); end
    endtask
    task automatic test_abort_cmd();
        snap();
        cmd_full = 1;
        start_line(64, 480, 0);
        abort = 1;
        @(negedge clk);
        abort = 0;
        checks++; if (line_busy !== 0) begin errors++; $display("FAIL abort_cmd_busy: got %0d expected 0", line_busy); end
        cmd_full = 0;
        repeat (3) @(negedge clk);
        checks++; if (cmd_count - c0 !== 0 || done_count - d0 !== 0) begin errors++; $display("FAIL abort_cmd_quiet: got %0d cmds %0d dones expected 0 0", cmd_count - c0, done_count - d0); end
    endtask
    task automatic test_req_with_abort();
        bit ok;
        snap();
        @(negedge clk);
        x_size = 64; y_size = 480; line_y = 3; line_req = 1; abort = 1;
        @(negedge clk);
        line_req = 0; abort = 0;
        checks++; if (line_busy !== 1) begin errors++; $display("FAIL req_abort_accept: got %0d expected 1", line_busy); end
        wait_idle(500, ok);
        checks++; if (done_count - d0 !== 1 || wr_count - w0 !== 64) begin errors++; $display("FAIL req_abort_line: got %0d dones %0d writes expected 1 64", done_count - d0, wr_count - w0); end
    endtask
    task automatic test_back_to_back();
        bit ok;
        snap();
        start_line(100, 480, 7);
        wait_idle(500, ok);
        start_line(100, 480, 8);
        wait_idle(500, ok);
        checks++; if (cmd_count - c0 !== 4) begin errors++; $display("FAIL b2b_cmds: got %0d expected 4", cmd_count - c0); end
        checks++; if (cbl[a0+1] !== 6'd35) begin errors++; $display("FAIL b2b_bl: got %0d expected 35", cbl[a0+1]); end
        checks++; if (caddr[a0+2] !== 30'd5246080) begin errors++; $display("FAIL b2b_addr: got %0d expected 5246080", caddr[a0+2]); end
        checks++; if (done_count - d0 !== 2 || wr_count - w0 !== 200) begin errors++; $display("FAIL b2b_totals: got %0d dones %0d writes expected 2 200", done_count - d0, wr_count - w0); end
    endtask
    task automatic test_reset_mid_drain();
        bit ok;
        snap();
        start_line(640, 480, 1);
        wait_wr(30, 500, ok);
        reset = 1;
        @(negedge clk);
        checks++; if ({cmd_en, rd_en, fifo_wr_en, line_busy, line_done} !== 5'b0) begin errors++; $display("FAIL midrst_flags: got %b expected 00000", {cmd_en, rd_en, fifo_wr_en, line_busy, line_done}); end
        checks++; if (cmd_instr !== 0 || cmd_bl !== 0 || cmd_byte_addr !== 0) begin errors++; $display("FAIL midrst_cmd: got %0d %0d %0d expected 0 0 0", cmd_instr, cmd_bl, cmd_byte_addr); end
        reset = 0; x_size = 64; line_y = 0; line_req = 1;
        @(negedge clk);
        checks++; if (line_busy !== 0) begin errors++; $display("FAIL midrst_sync1: got %0d expected 0", line_busy); end
        @(negedge clk);
        checks++; if (line_busy !== 0) begin errors++; $display("FAIL midrst_sync2: got %0d expected 0", line_busy); end
        line_req = 0;
        snap();
        start_line(64, 480, 0);
        wait_idle(500, ok);
        checks++; if (done_count - d0 !== 1 || wr_count - w0 !== 64) begin errors++; $display("FAIL midrst_after: got %0d dones %0d writes expected 1 64", done_count - d0, wr_count - w0); end
    endtask
    initial begin
        test_reset();
        test_line_640();
        test_line_800();
        test_backpressure();
        test_empty_line();
        test_cmd_full();
        test_abort_drain();
        test_abort_cmd();
        test_req_with_abort();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
